// File: rtl/nm_inv_stim_sequencer_if.sv
// nm_inv_stim_sequencer_if: run control, inverter stimulus/response and result signals
//   start, pause : run control (bench -> sequencer)
//   resp         : inverter outputs for the current stimulus
//   stim         : code driven to the inverter inputs
//   busy, done, pass, err_count, err_seen, first_err_code : run status and result
interface nm_inv_stim_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] resp;
  logic [WIDTH-1:0] stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       err_count;
  logic             err_seen;
  logic [WIDTH-1:0] first_err_code;
  modport master (
    output start, pause, resp,
    input  stim, busy, done, pass, err_count, err_seen, first_err_code
  );
  modport slave (
    input  start, pause, resp,
    output stim, busy, done, pass, err_count, err_seen, first_err_code
  );
endinterface

// File: rtl/nm_inv_stim_sequencer.sv
// nm_inv_stim_sequencer: steps codes 0..LAST_CODE, holds each SETTLE cycles, checks resp against ~stim
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of nm_inv_stim_sequencer_if (start/pause/resp in, stim and results out)
module nm_inv_stim_sequencer #(
  parameter int WIDTH     = 4,
  parameter int LAST_CODE = 9,
  parameter int SETTLE    = 3
) (
  input logic                    clk,
  input logic                    rst,
  nm_inv_stim_sequencer_if.slave bus
);
  localparam int TW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;
  state_t        state;
  logic [TW-1:0] timer;
  logic          mis;
  // case inequality so an X/Z response bit also counts as a mismatch in simulation
  assign mis = bus.resp !== ~bus.stim;
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      timer              <= '0;
      bus.stim           <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.err_count      <= '0;
      bus.err_seen       <= 1'b0;
      bus.first_err_code <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (bus.start) begin
          state              <= S_SETTLE;
          timer              <= '0;
          bus.stim           <= '0;
          bus.busy           <= 1'b1;
          bus.done           <= 1'b0;
          bus.pass           <= 1'b0;
          bus.err_count      <= '0;
          bus.err_seen       <= 1'b0;
          bus.first_err_code <= '0;
        end
        S_SETTLE: if (!bus.pause) begin
          timer <= timer + 1'b1;
          if (timer == TW'(SETTLE - 1)) state <= S_CHECK;
        end
        S_CHECK: if (!bus.pause) begin
          if (mis) begin
            bus.err_count <= bus.err_count == 8'hFF ? bus.err_count : bus.err_count + 8'd1;
            if (!bus.err_seen) begin
              bus.err_seen       <= 1'b1;
              bus.first_err_code <= bus.stim;
            end
          end
          if (bus.stim == WIDTH'(LAST_CODE)) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= !(bus.err_seen || mis);
          end else begin
            state    <= S_SETTLE;
            timer    <= '0;
            bus.stim <= bus.stim + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nm_inv_stim_sequencer.sv
// tb_nm_inv_stim_sequencer: directed runs with a done-triggered scoreboard for two parameterisations
module tb_nm_inv_stim_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic mode = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0_1 = 0;
  int   t0_2 = 0;
  logic d1_q = 1'b0;
  logic d2_q = 1'b0;
  typedef struct {
    logic [7:0] ec;
    logic       seen;
    logic [3:0] fec;
    logic       pass;
    int         lat;
  } exp_t;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1;
  exp_t e2;
  nm_inv_stim_sequencer_if #(.WIDTH(4)) b1 ();
  nm_inv_stim_sequencer_if #(.WIDTH(4)) b2 ();
  nm_inv_stim_sequencer #(.WIDTH(4), .LAST_CODE(9), .SETTLE(3)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  nm_inv_stim_sequencer #(.WIDTH(4), .LAST_CODE(15), .SETTLE(1)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // mode 0: ideal inverter; mode 1: bit0 output stuck at 0
  assign b1.resp = mode ? (~b1.stim & 4'b1110) : ~b1.stim;
  assign b2.resp = 4'hF;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic score(input string tag, input exp_t e, input logic [7:0] ec, input logic seen,
                       input logic [3:0] fec, input logic p, input int lat);
    chk({tag, "_err_count"}, 32'(ec), 32'(e.ec));
    chk({tag, "_err_seen"}, 32'(seen), 32'(e.seen));
    if (e.seen) chk({tag, "_first_err_code"}, 32'(fec), 32'(e.fec));
    chk({tag, "_pass"}, 32'(p), 32'(e.pass));
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_stim"}, 32'(b1.stim), 0);
    chk({tag, "_busy"}, 32'(b1.busy), 0);
    chk({tag, "_done"}, 32'(b1.done), 0);
    chk({tag, "_pass"}, 32'(b1.pass), 0);
    chk({tag, "_err_count"}, 32'(b1.err_count), 0);
    chk({tag, "_err_seen"}, 32'(b1.err_seen), 0);
    chk({tag, "_first_err_code"}, 32'(b1.first_err_code), 0);
  endtask
  always @(negedge clk) begin
    if (b1.done && !d1_q) begin
      if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
      else begin
        e1 = q1.pop_front();
        score("dut1", e1, b1.err_count, b1.err_seen, b1.first_err_code, b1.pass, cyc - t0_1);
      end
    end
    if (b2.done && !d2_q) begin
      if (q2.size() == 0) chk("dut2_unexpected_done", 1, 0);
      else begin
        e2 = q2.pop_front();
        score("dut2", e2, b2.err_count, b2.err_seen, b2.first_err_code, b2.pass, cyc - t0_2);
      end
    end
    d1_q <= b1.done;
    d2_q <= b2.done;
  end
  initial begin
    rst = 1'b1;
    b1.start = 1'b0;
    b1.pause = 1'b0;
    b2.start = 1'b0;
    b2.pause = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    q2.push_back('{8'd15, 1'b1, 4'd1, 1'b0, 32});
    b2.start = 1'b1;
    t0_2 = cyc + 1;
    @(negedge clk);
    b2.start = 1'b0;
    repeat (40) @(negedge clk);
    mode = 1'b1;
    q1.push_back('{8'd5, 1'b1, 4'd0, 1'b0, 40});
    b1.start = 1'b1;
    t0_1 = cyc + 1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      b1.start = (k == 9);
      if (k < 40) begin
        chk("walk_stim", 32'(b1.stim), 32'(k / 4));
        chk("walk_busy", 32'(b1.busy), 1);
      end
    end
    mode = 1'b0;
    q1.push_back('{8'd0, 1'b0, 4'd0, 1'b1, 40});
    b1.start = 1'b1;
    t0_1 = cyc + 1;
    @(negedge clk);
    b1.start = 1'b0;
    chk("restart_stim", 32'(b1.stim), 0);
    chk("restart_err_count", 32'(b1.err_count), 0);
    chk("restart_err_seen", 32'(b1.err_seen), 0);
    chk("restart_done", 32'(b1.done), 0);
    repeat (44) @(negedge clk);
    q1.push_back('{8'd0, 1'b0, 4'd0, 1'b1, 46});
    b1.start = 1'b1;
    t0_1 = cyc + 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      b1.start = 1'b0;
      b1.pause = (k >= 12 && k < 18);
      if (k >= 12 && k <= 21) chk("pause_stim_hold", 32'(b1.stim), 3);
    end
    mode = 1'b1;
    b1.start = 1'b1;
    t0_1 = cyc + 1;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      b1.start = 1'b0;
    end
    chk("midrun_stim", 32'(b1.stim), 5);
    chk("midrun_err_count", 32'(b1.err_count), 3);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    rst = 1'b0;
    mode = 1'b0;
    q1.push_back('{8'd0, 1'b0, 4'd0, 1'b1, 40});
    b1.start = 1'b1;
    t0_1 = cyc + 1;
    @(negedge clk);
    b1.start = 1'b0;
    repeat (44) @(negedge clk);
    chk("dut1_all_runs_done", 32'(q1.size()), 0);
    chk("dut2_all_runs_done", 32'(q2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nm_inv_stim_sequencer.md
# nm_inv_stim_sequencer

Synchronous stimulus sequencer and checker for the NMOS inverter bench. It steps a WIDTH-bit input code from 0 to LAST_CODE and holds each code for a programmable settle window so the switch-level inverter output can resolve. It then samples the inverter response against the expected inverted code and accumulates a mismatch count and first-failure record. It replaces free-running `initial`/`#delay` stimulus with a clocked, restartable run under a single clock.

## Interface
- WIDTH, 4, stimulus and response width in bits (one inverter per bit).
- LAST_CODE, 9, final code driven; run covers codes 0..LAST_CODE inclusive; must be < 2**WIDTH.
- SETTLE, 3, cycles each code is held before its check cycle; must be >= 1.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; honoured only in IDLE or DONE.
- pause  in  1  freezes sequencing while high during SETTLE/CHECK.
- resp  in  WIDTH  inverter outputs for the current stimulus.
- stim  out  WIDTH  code driven to the inverter inputs.
- busy  out  1  high from the start edge until DONE is entered.
- done  out  1  high in DONE; held until the next start or rst.
- pass  out  1  high in DONE when err_count == 0.
- err_count  out  8  mismatching checks, saturating at 255.
- err_seen  out  1  at least one mismatch this run.
- first_err_code  out  WIDTH  stim value of the first mismatch; valid when err_seen.

## Operation
- States: IDLE, SETTLE, CHECK, DONE. Internal timer sized for SETTLE-1.
- Reset: state IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, err_seen=0, first_err_code=0, timer=0. Reset mid-run aborts immediately with no partial result.
- IDLE/DONE with start=1:
  - go to SETTLE.
  - stim=0, timer=0, busy=1, done=0, pass=0.
  - clear err_count, err_seen and first_err_code.
- SETTLE (pause=0): timer increments each edge; on the edge where timer==SETTLE-1, go to CHECK.
- CHECK (pause=0), on its edge:
  - Compare resp with ~stim bitwise. Any differing bit, or any X/Z bit in simulation, is a mismatch.
  - On mismatch: err_count+1, holding at 255. If err_seen=0, set err_seen=1 and first_err_code=stim.
  - If stim==LAST_CODE: go to DONE, busy=0, done=1, pass=(no mismatch this run including this check).
  - Otherwise: stim=stim+1, timer=0, return to SETTLE.
- pause=1 in SETTLE/CHECK: state, timer and stim hold; no compare; busy stays 1. pause is ignored in IDLE and DONE.
- start while busy is ignored, with no restart. start and pause together in IDLE/DONE: start wins.
- stim changes only on the SETTLE entry edge. It is stable for SETTLE+1 cycles per code, so glitch-free stimulus is guaranteed to the inverter.

## Timing
- All outputs are registered; nothing is combinational from inputs.
- Per code: SETTLE cycles in SETTLE plus 1 cycle in CHECK = SETTLE+1 cycles.
- Run latency without pause: done rises (LAST_CODE+1)*(SETTLE+1) cycles after the start edge. Defaults: 40 cycles.
- Each pause cycle extends latency by exactly one cycle.
- resp is sampled on the CHECK edge, i.e. SETTLE+1 edges after stim took that value. Any inverter delay below SETTLE clock periods passes.
- err_count, err_seen and first_err_code update on the same edge as the failing check. done and pass assert on the edge of the final check.

## Test plan
- Ideal inverter model (resp=~stim), defaults, start pulse: stim walks 0..9, each held 4 cycles. Done at start+40, pass=1, err_count=0, err_seen=0.
- resp bit0 stuck at 0: mismatches occur on the even codes 0,2,4,6,8. Done at +40, err_count=5, first_err_code=0, pass=0.
- pause held high 6 cycles mid-SETTLE of code 3: stim stays 3 throughout; done at start+46; result unchanged vs ideal.
- Second start pulse at start+10 during busy: ignored, done still at +40. New start in DONE: counters clear, stim=0 the next cycle, and a second 40-cycle run completes.
- rst asserted during code 5: the next cycle shows IDLE with all outputs 0. A subsequent start gives a clean full run, with no residual err_count.
- LAST_CODE=15, SETTLE=1, resp tied to all ones: done at start+32; err_count=15 (only code 0 matches); first_err_code=1.
